// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
// Module   : branch_predictor
// Brief    : Direct-mapped BTB with 2-bit counters; gives a same-cycle fetch
//            prediction and a registered flush/redirect on mispredict.
// Revision : 1.0 - initial release
// ============================================================================
module branch_predictor #(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] if_pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        ex_valid,
    input  logic [31:0] ex_pc,
    input  logic        ex_is_branch,
    input  logic        ex_taken,
    input  logic [31:0] ex_target,
    input  logic        ex_pred_taken,
    input  logic [31:0] ex_pred_target,
    output logic        flush,
    output logic [31:0] redirect_pc,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispredicts
);
    localparam int c_TAG_W = 30 - IDX_W;

    logic [ENTRIES-1:0] r_valid;
    logic [c_TAG_W-1:0] r_tag    [ENTRIES];
    logic [31:0]        r_target [ENTRIES];
    logic [1:0]         r_ctr    [ENTRIES];
    logic               r_flush;
    logic [31:0]        r_redirect;
    logic [31:0]        r_stat_br;
    logic [31:0]        r_stat_mp;

    logic [IDX_W-1:0]   w_if_idx;
    logic [c_TAG_W-1:0] w_if_tag;
    logic               w_if_hit;
    logic [IDX_W-1:0]   w_ex_idx;
    logic [c_TAG_W-1:0] w_ex_tag;
    logic               w_ex_tag_eq;
    logic               w_ex_hit;
    logic               w_qual;
    logic               w_upd;
    logic               w_mis_a;
    logic               w_mis_b;
    logic [31:0]        w_ex_pc4;

    assign w_if_idx = if_pc[IDX_W+1:2];
    assign w_if_tag = if_pc[31:IDX_W+2];
    assign w_if_hit = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);

    assign pred_taken  = w_if_hit && r_ctr[w_if_idx][1];
    assign pred_target = pred_taken ? r_target[w_if_idx] : if_pc + 32'd4;

    assign w_ex_idx    = ex_pc[IDX_W+1:2];
    assign w_ex_tag    = ex_pc[31:IDX_W+2];
    assign w_ex_tag_eq = r_tag[w_ex_idx] == w_ex_tag;
    assign w_ex_hit    = r_valid[w_ex_idx] && w_ex_tag_eq;
    assign w_ex_pc4    = ex_pc + 32'd4;

    // The EX slot in a flush cycle holds a wrong-path instruction.
    assign w_qual  = ex_valid && !r_flush;
    assign w_upd   = w_qual && ex_is_branch;
    assign w_mis_a = w_upd && ((ex_taken != ex_pred_taken) ||
                               (ex_taken && (ex_target != ex_pred_target)));
    assign w_mis_b = w_qual && !ex_is_branch && ex_pred_taken;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_valid    <= '0;
            r_flush    <= 1'b0;
            r_redirect <= '0;
            r_stat_br  <= '0;
            r_stat_mp  <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_ctr[i]    <= 2'b01;
            end
        end else begin
            r_flush <= w_mis_a || w_mis_b;
            if (w_upd) begin
                if (w_ex_hit) begin
                    if (ex_taken) begin
                        r_target[w_ex_idx] <= ex_target;
                        if (r_ctr[w_ex_idx] != 2'b11)
                            r_ctr[w_ex_idx] <= r_ctr[w_ex_idx] + 2'b01;
                    end else if (r_ctr[w_ex_idx] != 2'b00) begin
                        r_ctr[w_ex_idx] <= r_ctr[w_ex_idx] - 2'b01;
                    end
                end else if (ex_taken) begin
                    r_valid[w_ex_idx]  <= 1'b1;
                    r_tag[w_ex_idx]    <= w_ex_tag;
                    r_target[w_ex_idx] <= ex_target;
                    r_ctr[w_ex_idx]    <= 2'b10;
                end
                if (r_stat_br != 32'hFFFF_FFFF)
                    r_stat_br <= r_stat_br + 32'd1;
            end
            if (w_mis_a)
                r_redirect <= ex_taken ? ex_target : w_ex_pc4;
            if (w_mis_b) begin
                r_redirect <= w_ex_pc4;
                if (w_ex_tag_eq)
                    r_valid[w_ex_idx] <= 1'b0;
            end
            if ((w_mis_a || w_mis_b) && (r_stat_mp != 32'hFFFF_FFFF))
                r_stat_mp <= r_stat_mp + 32'd1;
        end
    end

    assign flush            = r_flush;
    assign redirect_pc      = r_redirect;
    assign stat_branches    = r_stat_br;
    assign stat_mispredicts = r_stat_mp;

endmodule
`default_nettype wire
